// File: rtl/mario_dma_if.sv
// mario_dma_if: trigger/status and RAM-port bundle of the sprite/object DMA.
// The engine takes the master side; the CPU latch and RAM side takes slave.
interface mario_dma_if #(
  parameter int AW = 10
);
  logic          I_DMA_TRIG;
  logic          I_HOLD;
  logic          I_ABORT;
  logic          I_MODE;
  logic [7:0]    I_FILL_D;
  logic [7:0]    I_DMA_DS;
  logic [AW-1:0] O_DMA_AS;
  logic          O_DMA_CES;
  logic [AW-1:0] O_DMA_AD;
  logic [7:0]    O_DMA_DD;
  logic          O_DMA_CED;
  logic          O_BUSY;
  logic          O_DONE;

  modport master (
    input  I_DMA_TRIG, I_HOLD, I_ABORT,
    input  I_MODE, I_FILL_D, I_DMA_DS,
    output O_DMA_AS, O_DMA_CES,
    output O_DMA_AD, O_DMA_DD, O_DMA_CED,
    output O_BUSY, O_DONE
  );

  modport slave (
    output I_DMA_TRIG, I_HOLD, I_ABORT,
    output I_MODE, I_FILL_D, I_DMA_DS,
    input  O_DMA_AS, O_DMA_CES,
    input  O_DMA_AD, O_DMA_DD, O_DMA_CED,
    input  O_BUSY, O_DONE
  );
endinterface

// File: rtl/mario_dma_ctrl.sv
// mario_dma_ctrl: parametrised sprite/object DMA engine on the 4 MHz CEN.
// Fill mode is compiled in only when MARIO_DMA_FILL_EN is defined.
module mario_dma_ctrl #(
  parameter int AW       = 10,
  parameter int LEN      = 384,
  parameter int SRC_BASE = 'h100,
  parameter int DST_BASE = 'h000,
  parameter int READ_LAT = 1
) (
  input  logic        I_CLK_48M,
  input  logic        I_RESET_n,
  input  logic        I_CEN_4M,
  mario_dma_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [AW:0]   LEN_C = (AW+1)'(LEN);
  localparam logic [AW:0]   ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] SRC_B = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_B = AW'(DST_BASE);

  state_e              state_q, state_d;
  logic                trig_q, trig_d;
  logic                pend_q, pend_d;
  logic [AW:0]         rd_q, rd_d;
  logic [AW:0]         wr_q, wr_d;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]       as_q, as_d;
  logic [AW-1:0]       ad_q, ad_d;
  logic [7:0]          dd_q, dd_d;
  logic                ces_q, ces_d;
  logic                ced_q, ced_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_edge, go, issue;
`ifdef MARIO_DMA_FILL_EN
  logic                mode_q, mode_d;
  logic [7:0]          fill_q, fill_d;
`else
  logic                unused_fill;
  assign unused_fill = ^{bus.I_MODE, bus.I_FILL_D};
`endif

  assign start_edge = bus.I_DMA_TRIG & ~trig_q;

  always_comb begin
    state_d = state_q;
    trig_d  = bus.I_DMA_TRIG;
    pend_d  = pend_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    vld_d   = '0;
    as_d    = as_q;
    ces_d   = 1'b0;
    ad_d    = ad_q;
    dd_d    = dd_q;
    ced_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    go      = 1'b0;
    issue   = 1'b0;
`ifdef MARIO_DMA_FILL_EN
    mode_d  = mode_q;
    fill_d  = fill_q;
`endif
    if (bus.I_ABORT) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      rd_d    = '0;
      wr_d    = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: go = start_edge | pend_q;
        S_RUN: begin
          pend_d = pend_q | start_edge;
          if (wr_q == LEN_C) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
`ifdef MARIO_DMA_FILL_EN
          else if (mode_q) begin
            if (!bus.I_HOLD) begin
              ad_d  = DST_B + wr_q[AW-1:0];
              dd_d  = fill_q;
              ced_d = 1'b1;
              wr_d  = wr_q + ONE;
            end
          end
`endif
          else begin
            issue = !bus.I_HOLD && (rd_q < LEN_C);
            if (issue) begin
              as_d  = SRC_B + rd_q[AW-1:0];
              ces_d = 1'b1;
              rd_d  = rd_q + ONE;
            end
            // oldest in-flight read lands READ_LAT CEN cycles after issue
            vld_d[0] = issue;
            for (int i = 1; i < READ_LAT; i++)
              vld_d[i] = vld_q[i-1];
            if (vld_q[READ_LAT-1]) begin
              ad_d  = DST_B + wr_q[AW-1:0];
              dd_d  = bus.I_DMA_DS;
              ced_d = 1'b1;
              wr_d  = wr_q + ONE;
            end
          end
        end
        S_DONE: begin
          if (start_edge | pend_q) go = 1'b1;
          else state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (go) begin
        state_d = S_RUN;
        pend_d  = 1'b0;
        rd_d    = '0;
        wr_d    = '0;
        busy_d  = 1'b1;
`ifdef MARIO_DMA_FILL_EN
        mode_d  = bus.I_MODE;
        fill_d  = bus.I_FILL_D;
`endif
      end
    end
  end

  always_ff @(posedge I_CLK_48M or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      pend_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      vld_q   <= '0;
      as_q    <= '0;
      ces_q   <= 1'b0;
      ad_q    <= '0;
      dd_q    <= '0;
      ced_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MARIO_DMA_FILL_EN
      mode_q  <= 1'b0;
      fill_q  <= '0;
`endif
    end else if (I_CEN_4M) begin
      state_q <= state_d;
      trig_q  <= trig_d;
      pend_q  <= pend_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      vld_q   <= vld_d;
      as_q    <= as_d;
      ces_q   <= ces_d;
      ad_q    <= ad_d;
      dd_q    <= dd_d;
      ced_q   <= ced_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MARIO_DMA_FILL_EN
      mode_q  <= mode_d;
      fill_q  <= fill_d;
`endif
    end
  end

  assign bus.O_DMA_AS  = as_q;
  assign bus.O_DMA_CES = ces_q;
  assign bus.O_DMA_AD  = ad_q;
  assign bus.O_DMA_DD  = dd_q;
  assign bus.O_DMA_CED = ced_q;
  assign bus.O_BUSY    = busy_q;
  assign bus.O_DONE    = done_q;
endmodule

// File: doc/mario_dma_ctrl.md
# mario_dma_ctrl

Parametrised sprite/object DMA engine, the successor to the fixed sprite DMA. It copies a configurable block from a source RAM read port to a destination RAM write port in the main CPU subsystem. Main-CPU latch outputs start it, and it runs on the 4 MHz CPU clock enable. Over the fixed engine it adds configurable base addresses, length and source-read latency, busy/done status, a one-deep retrigger queue, hold and abort, and an optional fill mode.

## Interface
Parameters:
- AW, 10, source/destination address width
- LEN, 384, transfer length in bytes; range 1..2^AW
- SRC_BASE, 'h100, first source address
- DST_BASE, 'h000, first destination address
- READ_LAT, 1, source read latency in CEN cycles; range 1..3

Ports:
- I_CLK_48M  in  1  system clock, the single clock
- I_RESET_n  in  1  asynchronous active-low reset
- I_CEN_4M  in  1  clock enable; all state advances only on edges where it is high (a "CEN cycle")
- I_DMA_TRIG  in  1  start request, rising-edge sensitive
- I_HOLD  in  1  suspends issuing of new source reads
- I_ABORT  in  1  cancels the transfer
- I_MODE  in  1  0 = copy, 1 = fill; ignored unless MARIO_DMA_FILL_EN is defined
- I_FILL_D  in  8  fill byte
- I_DMA_DS  in  8  source read data
- O_DMA_AS  out  AW  source address
- O_DMA_CES  out  1  source read enable
- O_DMA_AD  out  AW  destination address
- O_DMA_DD  out  8  destination write data
- O_DMA_CED  out  1  destination write enable
- O_BUSY  out  1  transfer in progress
- O_DONE  out  1  one-CEN-cycle completion pulse

## Operation
- Reset: all outputs 0, state IDLE, counters 0, pending flag 0.
- trig_q resets to 0. A trigger already high at reset release therefore starts a transfer on the first CEN cycle.
- Edge detect: start_edge = I_DMA_TRIG & ~trig_q. trig_q is updated every CEN cycle.
- States: IDLE, RUN, DONE.
- IDLE -> RUN:
  - Transition occurs on start_edge, or when the pending flag is set.
  - On the transition: rd_cnt = 0, wr_cnt = 0, pending = 0, O_BUSY = 1.
- RUN, read issue:
  - Each CEN cycle with rd_cnt < LEN and I_HOLD = 0 issues one read.
  - The issued read sets O_DMA_AS = (SRC_BASE + rd_cnt) mod 2^AW and O_DMA_CES = 1, then increments rd_cnt.
  - Otherwise O_DMA_CES = 0 and O_DMA_AS holds.
- RUN, write:
  - A READ_LAT-deep valid shift register tracks in-flight reads.
  - When a valid entry emerges, the engine writes O_DMA_AD = (DST_BASE + wr_cnt) mod 2^AW and O_DMA_DD = I_DMA_DS, sets O_DMA_CED = 1, and increments wr_cnt.
  - Otherwise O_DMA_CED = 0.
- Hold: in-flight reads still complete and are written. Hold only stops new issues.
- RUN -> DONE: taken on the CEN cycle after the write with wr_cnt = LEN-1. In DONE, O_DONE = 1 and O_BUSY = 0.
- DONE -> IDLE: taken on the next CEN cycle, with O_DONE = 0. If pending is set, the engine goes straight to RUN instead.
- Retrigger: a start_edge in RUN or DONE sets pending. It is one deep; further edges are absorbed.
- Abort:
  - I_ABORT = 1 on a CEN cycle in any state forces IDLE and clears pending, counters, CES and CED.
  - O_BUSY = 0, and no O_DONE pulse is produced.
  - Abort wins over a simultaneous start_edge.
- Counters are AW+1 bits wide, so LEN = 2^AW is representable. Address addition wraps modulo 2^AW.

## Timing
- All registered outputs change only on CEN cycles and hold for the full CEN period. A strobe spans 12 I_CLK_48M cycles.
- Let cycle 0 be the start CEN cycle (RUN entered, O_BUSY = 1). With no hold:
  - reads are issued on cycles 1..LEN;
  - the write for the read issued on cycle c occurs on cycle c+READ_LAT;
  - DONE occurs on cycle LEN+READ_LAT+1.
- Source data is sampled exactly READ_LAT CEN cycles after the address is registered.
- Pending restart: DONE on cycle d, RUN on cycle d+1, first read on cycle d+2.
- Asynchronous reset mid-transfer: outputs clear immediately. No further writes occur.

## Configuration
- MARIO_DMA_FILL_EN defined, with I_MODE = 1 latched at start:
  - no source reads are issued (O_DMA_CES stays 0);
  - one destination write per non-held CEN cycle, on cycles 1..LEN, with O_DMA_DD = I_FILL_D latched at start;
  - DONE occurs on cycle LEN+1.
- MARIO_DMA_FILL_EN undefined: I_MODE and I_FILL_D are ignored, and only copy mode exists.

## Test plan
- Default parameters, single trigger:
  - first read at O_DMA_AS = 'h100 on cycle 1; first write at O_DMA_AD = 'h000 with data from 'h100 on cycle 2;
  - last write at O_DMA_AD = 'h17F on cycle 385; O_DONE on cycle 386; exactly 384 CED strobes.
- I_HOLD high on cycles 10..19, READ_LAT = 2:
  - no reads are issued during the hold, and the two in-flight writes still complete;
  - DONE moves to cycle 397; data stays in order.
- Second trigger edge on cycle 50, third on cycle 60:
  - exactly one extra transfer follows; its first read is on cycle 388;
  - total of 768 CED strobes.
- I_ABORT on cycle 100:
  - O_BUSY = 0 on cycle 100, no O_DONE, and no CED after cycle 100;
  - a new trigger then restarts from 'h100.
- AW = 4, LEN = 16, SRC_BASE = 'hC: source addresses wrap C, D, E, F, 0, ..., B.
- With MARIO_DMA_FILL_EN, I_MODE = 1, I_FILL_D = 'hF8:
  - 384 writes of 'hF8 to 'h000..'h17F, no CES;
  - DONE on cycle 385.
